pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-byte fetch sequencer for the 8-bit CPU. It owns the 16-bit PC, fetches one byte at a time from program memory over a req/ack handshake, and presents each byte to the decoder over a valid/ready handshake. It is the consumer of the jump unit's `pcoe`/`pcout` pair and the producer of that unit's `pcin`. On a taken jump it loads the PC with the jump target and discards any byte fetched from the old stream.

## Interface
- `RESET_PC`, default 16'h0000: PC value after reset.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `halt`  in  1: when high in IDLE, no new fetch starts; ignored in other states.
- `jmp_load`  in  1: taken jump (driven by jump unit `pcoe`).
- `jmp_target`  in  16: jump target (jump unit `pcout`); sampled only when `jmp_load` = 1.
- `pc`  out  16: next byte address to fetch; feeds jump unit `pcin`.
- `mem_req`  out  1: fetch request to program memory.
- `mem_addr`  out  16: fetch address; registered, stable while `mem_req` = 1.
- `mem_ack`  in  1: memory returns `mem_rdata` this cycle; only meaningful while `mem_req` = 1.
- `mem_rdata`  in  8: fetched byte.
- `ins_valid`  out  1: `ins` holds a valid byte.
- `ins`  out  8: fetched byte (opcode or operand; decoder decides).
- `ins_ready`  in  1: decoder consumes `ins` when `ins_valid` & `ins_ready`.

## Operation
- States:
  - IDLE: `mem_req` = 0, `ins_valid` = 0.
  - FETCH: `mem_req` = 1.
  - HOLD: `ins_valid` = 1.
- `kill` flag (internal): set by a jump during an outstanding fetch.
- IDLE:
  - `halt` = 0: `mem_addr` <= `pc`, go to FETCH.
  - `halt` = 1: stay in IDLE.
  - `jmp_load` loads `pc` <= `jmp_target` in either case. If also leaving IDLE, `mem_addr` takes `jmp_target`.
- FETCH, `mem_ack` = 0: stay. `mem_req` and `mem_addr` are held; a request is never withdrawn before ack.
- FETCH, `mem_ack` = 1 and `kill` = 0:
  - `ins` <= `mem_rdata`, `pc` <= `pc` + 1, go to HOLD.
- FETCH, `mem_ack` = 1 and `kill` = 1:
  - Data discarded; `kill` <= 0; `pc` unchanged (already the target).
  - `mem_addr` <= `pc`; stay in FETCH with a new request.
- FETCH with `jmp_load`:
  - `pc` <= `jmp_target`.
  - If `mem_ack` is not also high this cycle, `kill` <= 1.
  - If `mem_ack` is high the same cycle, the returned byte is discarded, `pc` = target, and a new FETCH starts from the target.
- HOLD:
  - On handshake with no jump: `mem_addr` <= `pc`, go to FETCH.
  - `jmp_load` (with or without handshake): `pc` <= `jmp_target`, `ins_valid` drops, `mem_addr` <= `jmp_target`, go to FETCH. A jump takes priority over `pc` + 1.
- Arithmetic:
  - `pc` + 1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - No other arithmetic; relative targets are computed by the jump unit from `pc`.
- `pc` semantics: while a byte is in HOLD, `pc` = (address of that byte) + 1. A jump issued on the last operand's handshake therefore sees `pc` pointing past the instruction.

## Timing
- Reset values:
  - `pc` = RESET_PC, state IDLE, `kill` = 0.
  - `mem_req` = 0, `mem_addr` = 0.
  - `ins_valid` = 0, `ins` = 0.
- `rst` asserted mid-fetch: `mem_req` is low the cycle after the reset edge, and the outstanding ack is ignored. Memory must tolerate an abandoned request on reset.
- First request: `mem_req` rises 1 cycle after `rst` deasserts (IDLE then FETCH), with `halt` = 0.
- Zero-wait memory (ack in the first FETCH cycle): `ins_valid` rises the next cycle.
- Steady-state throughput: 1 byte per 2 cycles with zero-wait memory and `ins_ready` tied high. There is no prefetch beyond one byte.
- Every wait-state cycle adds 1 cycle. Every `ins_ready` = 0 cycle in HOLD adds 1 cycle.
- Jump from HOLD: a request to the target is issued the next cycle. Any in-flight byte is never presented.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Sequential fetch: reset with RESET_PC = 0, memory returns `addr[7:0]`, zero-wait, `ins_ready` = 1. Expect `ins` = 00, 01, 02 on `ins_valid` every other cycle, and `pc` = 1, 2, 3 in HOLD.
- Wait states and backpressure: ack delayed 3 cycles and `ins_ready` low 2 cycles. Expect `mem_addr` stable throughout, byte held in `ins`, and no `pc` change until the handshake.
- Jump in HOLD: `jmp_load` = 1 with `jmp_target` = 16'h1234 during a handshake. Expect `ins_valid` = 0 next cycle, `mem_addr` = 1234, then `pc` = 1235 after ack.
- Jump during pending fetch: jump to 16'h0040 while a fetch at 16'h0010 waits 2 cycles. Expect the 0010 data never to appear on `ins`, followed by a request at 0040.
- Wraparound: RESET_PC = 16'hFFFF. Expect the first byte from FFFF, `pc` = 0000, next request at 0000.
- Reset mid-fetch: assert `rst` during FETCH with ack pending. Expect `mem_req` = 0 and `pc` = RESET_PC next cycle, and an ack arriving during reset has no effect.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and single-byte instruction fetch sequencer.
// Fetches one byte per memory handshake and hands it to the decoder; jumps redirect the stream.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset; waits for halt to drop before first fetch
// FETCH | mem_req high, waiting for mem_ack
// HOLD  | fetched byte presented on ins, waiting for ins_ready
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        jmp_load,
  input  logic [15:0] jmp_target,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        ins_valid,
  output logic [7:0]  ins,
  input  logic        ins_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_d;
  logic [15:0] addr_d;
  logic [7:0]  ins_d;
  logic        kill_q, kill_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    addr_d  = mem_addr;
    ins_d   = ins;
    kill_d  = kill_q;

    case (state_q)
      S_IDLE: begin
        if (jmp_load)
          pc_d = jmp_target;
        if (!halt) begin
          addr_d  = jmp_load ? jmp_target : pc;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (jmp_load) begin
          pc_d = jmp_target;
          // A byte acked alongside the jump is dropped and the target request
          // issues straight away; otherwise the in-flight byte must be killed.
          if (mem_ack) begin
            addr_d = jmp_target;
            kill_d = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (mem_ack) begin
          if (kill_q) begin
            kill_d = 1'b0;
            addr_d = pc;
          end else begin
            ins_d   = mem_rdata;
            pc_d    = pc + 16'd1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (jmp_load) begin
          pc_d    = jmp_target;
          addr_d  = jmp_target;
          state_d = S_FETCH;
        end else if (ins_ready) begin
          addr_d  = pc;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc        <= RESET_PC;
      kill_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 16'h0000;
      ins_valid <= 1'b0;
      ins       <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      kill_q    <= kill_d;
      mem_addr  <= addr_d;
      ins       <= ins_d;
      // Handshake outputs are flops of the next state so nothing reaches a port combinationally.
      mem_req   <= (state_d == S_FETCH);
      ins_valid <= (state_d == S_HOLD);
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by random traffic against a byte-stream reference model.
// A second instance with RESET_PC = FFFF covers PC wraparound.
module tb_pc_fetch;

  logic        clk, rst, halt, jmp_load, ins_ready;
  logic [15:0] jmp_target;
  logic        mem_ack, ack_mem, force_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] pc, mem_addr;
  logic        mem_req, ins_valid;
  logic [7:0]  ins;
  logic [15:0] w_pc, w_mem_addr;
  logic        w_mem_req, w_ins_valid;
  logic [7:0]  w_ins, w_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_lat = 0;
  bit rand_phase = 0;
  int hs_cnt = 0;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign mem_ack = ack_mem | force_ack;
  assign w_rdata = mem_f(w_mem_addr);

  pc_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .halt(halt), .jmp_load(jmp_load), .jmp_target(jmp_target),
    .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready)
  );

  pc_fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .halt(halt), .jmp_load(jmp_load), .jmp_target(jmp_target),
    .pc(w_pc), .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack), .mem_rdata(w_rdata),
    .ins_valid(w_ins_valid), .ins(w_ins), .ins_ready(ins_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Program memory: wait_lat wait states per request, sampled when a new request starts.
  initial begin : memory
    int  wait_cnt;
    logic prev_req, prev_ack;
    wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
    ack_mem = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        if (!prev_req || prev_ack)
          wait_cnt = wait_lat;
        if (wait_cnt == 0) ack_mem = 1'b1;
        else begin
          ack_mem = 1'b0;
          wait_cnt--;
        end
      end else begin
        ack_mem = 1'b0;
      end
      mem_rdata = ack_mem ? mem_f(mem_addr) : 8'($urandom);
      prev_req = mem_req;
      prev_ack = ack_mem;
    end
  end

  // Reference model: the decoder must see the byte stream starting at the reset PC,
  // advancing by one per consumed byte, restarting at the target after any jump.
  initial begin : model
    logic [15:0] exp_next, nxt, p_addr;
    logic        p_req, p_ack, p_rst;
    bit          live;
    int          stall;
    exp_next = 16'h0000; live = 0; stall = 0;
    p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = 16'h0000;
    forever begin
      @(negedge clk);
      if (live) begin
        if (ins_valid) begin
          nxt = exp_next + 16'd1;
          chk("m_ins", {24'h0, ins}, {24'h0, mem_f(exp_next)});
          chk("m_pc_hold", {16'h0, pc}, {16'h0, nxt});
        end else begin
          chk("m_pc", {16'h0, pc}, {16'h0, exp_next});
        end
        if (p_req && !p_ack && !p_rst) begin
          chk("m_req_held", {31'h0, mem_req}, 32'h1);
          chk("m_addr_held", {16'h0, mem_addr}, {16'h0, p_addr});
        end
        if ((ins_valid && ins_ready) || rst) stall = 0;
        else stall++;
        if (stall > 300) begin
          chk("m_stall", stall, 0);
          stall = 0;
        end
        if (rand_phase && ins_valid && ins_ready && !rst) hs_cnt++;
      end
      p_req = mem_req; p_ack = mem_ack; p_rst = rst; p_addr = mem_addr;
      if (rst) begin
        exp_next = 16'h0000;
        live = 1;
      end else begin
        if (ins_valid && ins_ready) exp_next = exp_next + 16'd1;
        if (jmp_load) exp_next = jmp_target;
      end
    end
  end

  initial begin : driver
    int n;
    rst = 1'b1; halt = 1'b0; jmp_load = 1'b0; jmp_target = 16'h0000;
    ins_ready = 1'b1; force_ack = 1'b0; wait_lat = 0;
    repeat (3) cyc();
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_ins", {24'h0, ins}, 32'h0);
    chk("rst_w_pc", {16'h0, w_pc}, 32'hFFFF);

    // Sequential zero-wait fetch
    rst = 1'b0;
    cyc();
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'h0);
    chk("w_first_addr", {16'h0, w_mem_addr}, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("seq_valid", {31'h0, ins_valid}, 32'h1);
      chk("seq_ins", {24'h0, ins}, i);
      chk("seq_pc", {16'h0, pc}, i + 1);
      if (i == 0) begin
        chk("w_wrap_pc", {16'h0, w_pc}, 32'h0);
        chk("w_wrap_ins", {24'h0, w_ins}, 32'h0);
      end
      cyc();
      chk("seq_gap", {31'h0, ins_valid}, 32'h0);
      chk("seq_addr", {16'h0, mem_addr}, i + 1);
      if (i == 0) chk("w_wrap_addr", {16'h0, w_mem_addr}, 32'h0);
    end

    // Three wait states, then two cycles of backpressure
    wait_lat = 3; ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_req", {31'h0, mem_req}, 32'h1);
      chk("ws_addr", {16'h0, mem_addr}, 32'h3);
      chk("ws_pc", {16'h0, pc}, 32'h3);
    end
    cyc();
    chk("ws_valid", {31'h0, ins_valid}, 32'h1);
    chk("ws_ins", {24'h0, ins}, 32'h3);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("bp_valid", {31'h0, ins_valid}, 32'h1);
      chk("bp_ins", {24'h0, ins}, 32'h3);
      chk("bp_pc", {16'h0, pc}, 32'h4);
    end

    // Jump on a HOLD handshake
    ins_ready = 1'b1; jmp_load = 1'b1; jmp_target = 16'h1234; wait_lat = 0;
    cyc();
    jmp_load = 1'b0;
    chk("jh_valid", {31'h0, ins_valid}, 32'h0);
    chk("jh_addr", {16'h0, mem_addr}, 32'h1234);
    cyc();
    chk("jh_ins", {24'h0, ins}, 32'h26);
    chk("jh_pc", {16'h0, pc}, 32'h1235);

    // Jump while a fetch is waiting
    jmp_load = 1'b1; jmp_target = 16'h0010; wait_lat = 2;
    cyc();
    chk("jf_addr0", {16'h0, mem_addr}, 32'h0010);
    jmp_target = 16'h0040;
    cyc();
    jmp_load = 1'b0;
    chk("jf_addr1", {16'h0, mem_addr}, 32'h0010);
    chk("jf_pc", {16'h0, pc}, 32'h0040);
    cyc();
    chk("jf_held", {16'h0, mem_addr}, 32'h0010);
    cyc();
    chk("jf_req", {31'h0, mem_req}, 32'h1);
    chk("jf_retarget", {16'h0, mem_addr}, 32'h0040);
    chk("jf_novalid", {31'h0, ins_valid}, 32'h0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ins_valid && n < 10);
    chk("jf_valid", {31'h0, ins_valid}, 32'h1);
    chk("jf_ins", {24'h0, ins}, 32'h40);
    chk("jf_pc2", {16'h0, pc}, 32'h41);

    // Reset while a fetch is outstanding, ack arriving during reset
    wait_lat = 3;
    cyc();
    chk("rm_req", {31'h0, mem_req}, 32'h1);
    chk("rm_addr", {16'h0, mem_addr}, 32'h41);
    rst = 1'b1; force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rm_req_low", {31'h0, mem_req}, 32'h0);
      chk("rm_pc", {16'h0, pc}, 32'h0);
      chk("rm_valid", {31'h0, ins_valid}, 32'h0);
    end

    // Halt in IDLE, with a jump taken while halted
    rst = 1'b0; force_ack = 1'b0; halt = 1'b1;
    cyc();
    chk("halt_req", {31'h0, mem_req}, 32'h0);
    jmp_load = 1'b1; jmp_target = 16'hABCD;
    cyc();
    jmp_load = 1'b0;
    chk("halt_pc", {16'h0, pc}, 32'hABCD);
    chk("halt_req2", {31'h0, mem_req}, 32'h0);
    halt = 1'b0; wait_lat = 0;
    cyc();
    chk("unhalt_req", {31'h0, mem_req}, 32'h1);
    chk("unhalt_addr", {16'h0, mem_addr}, 32'hABCD);

    // Random traffic
    rand_phase = 1;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst        = ($urandom_range(0, 249) == 0);
      halt       = ($urandom_range(0, 3) == 0);
      ins_ready  = ($urandom_range(0, 3) != 0);
      jmp_load   = ($urandom_range(0, 11) == 0);
      jmp_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      wait_lat   = $urandom_range(0, 3);
    end
    rst = 1'b0; jmp_load = 1'b0; halt = 1'b0;
    repeat (3) cyc();
    rand_phase = 0;
    chk("rand_progress", {31'h0, (hs_cnt > 200)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
